// File: rtl/seq_mult_n.sv
// seq_mult_n: iterative shift-add multiplier, one partial product per clock.
// Signed or unsigned per operation; registered 2N-bit product with done strobe.
//
// Ports:
//   clk    rising-edge clock
//   resetn async active-low reset
//   start  request a multiply (sampled when busy=0)
//   sgn    1 = two's-complement operands, 0 = unsigned
//   a, b   N-bit multiplicand / multiplier
//   busy   high while iterating
//   done   one-cycle pulse, p valid
//   p      2N-bit product, held until next completion
module seq_mult_n #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nx;
  logic [2*N-1:0] addend;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           load;
  logic           last;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  // Magnitude of the most negative value wraps to itself,
  // which is the correct unsigned magnitude 2^(N-1).
  assign a_mag = (sgn && a[N-1]) ? -a : a;
  assign b_mag = (sgn && b[N-1]) ? -b : b;

  assign last   = (cnt == CW'(N-1));
  assign addend = mplier[0]
                ? ({{N{1'b0}}, mcand} << cnt)
                : '0;
  assign acc_nx = acc + addend;

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = FIN;
      end
      FIN: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= sgn & (a[N-1] ^ b[N-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_nx;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        // Only the completed product is ever exposed on p.
        if (last) p <= neg ? -acc_nx : acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: directed checks for seq_mult_n at N=8 and N=4
// against a cycle-level behavioural model of the handshake.
module tb_seq_mult_n;

  logic clk;
  logic resetn;

  logic        start8, s8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        start4, s4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  p4;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  seq_mult_n #(.N(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .sgn(s8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_mult_n #(.N(4)) dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .sgn(s4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [63:0] prod(input int n, input logic [31:0] x,
                                       input logic [31:0] y, input bit s);
    longint sx, sy, r;
    sx = longint'({32'b0, x});
    sy = longint'({32'b0, y});
    if (s && x[n-1]) sx = sx - (64'sd1 <<< n);
    if (s && y[n-1]) sy = sy - (64'sd1 <<< n);
    r = sx * sy;
    return r & ((64'd1 << (2*n)) - 1);
  endfunction

  // Model: accepted start => busy for N cycles, then one done cycle
  // carrying the exact product; p holds between completions.
  int rl8, rl4;
  bit fin8, fin4;
  logic [15:0] ep8, pend8;
  logic [7:0]  ep4, pend4;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rl8 <= 0; fin8 <= 0; ep8 <= '0; pend8 <= '0;
    end else if (rl8 > 0) begin
      rl8  <= rl8 - 1;
      fin8 <= (rl8 == 1);
      if (rl8 == 1) ep8 <= pend8;
    end else begin
      fin8 <= 0;
      if (start8) begin
        pend8 <= 16'(prod(8, 32'(a8), 32'(b8), s8));
        rl8   <= 8;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rl4 <= 0; fin4 <= 0; ep4 <= '0; pend4 <= '0;
    end else if (rl4 > 0) begin
      rl4  <= rl4 - 1;
      fin4 <= (rl4 == 1);
      if (rl4 == 1) ep4 <= pend4;
    end else begin
      fin4 <= 0;
      if (start4) begin
        pend4 <= 8'(prod(4, 32'(a4), 32'(b4), s4));
        rl4   <= 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy8", busy8, rl8 > 0);
      chk("done8", done8, fin8);
      chk("p8", p8, ep8);
      chk("excl8", busy8 & done8, 0);
      chk("busy4", busy4, rl4 > 0);
      chk("done4", done4, fin4);
      chk("p4", p4, ep4);
      chk("excl4", busy4 & done4, 0);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input bit s, output int kd, output int bc);
    start8 = 1; a8 = x; b8 = y; s8 = s;
    kd = 0; bc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 0;
      if (done8) begin
        kd = k;
        break;
      end
      if (busy8) bc++;
    end
    chk("op8_done_seen", kd != 0, 1);
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y,
                     input bit s);
    int kd;
    start4 = 1; a4 = x; b4 = y; s4 = s;
    kd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 0;
      if (done4) begin
        kd = k;
        break;
      end
    end
    chk("op4_latency", kd, 5);
    chk("op4_p", p4, 8'(prod(4, 32'(x), 32'(y), s)));
  endtask

  initial begin
    int kd, bc, nd, k1;
    resetn = 0;
    start8 = 0; s8 = 0; a8 = 0; b8 = 0;
    start4 = 0; s4 = 0; a4 = 0; b4 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_p4", p4, 0);
    resetn = 1;
    chk_on = 1;
    @(negedge clk);

    op8(8'hFF, 8'hFF, 0, kd, bc);
    chk("t1_done_cycle", kd, 9);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_p", p8, 16'hFE01);
    repeat (3) @(negedge clk);
    chk("t1_hold", p8, 16'hFE01);

    op8(8'h80, 8'h80, 1, kd, bc);
    chk("s_80x80", p8, 16'h4000);
    @(negedge clk);
    op8(8'hFF, 8'h7F, 1, kd, bc);
    chk("s_FFx7F", p8, 16'hFF81);
    @(negedge clk);
    op8(8'h00, 8'h80, 1, kd, bc);
    chk("s_00x80", p8, 16'h0000);
    repeat (2) @(negedge clk);

    start8 = 1; a8 = 3; b8 = 5; s8 = 0;
    nd = 0; k1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 0;
      if (k == 3) begin
        start8 = 1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1;
      end
      if (k == 4) start8 = 0;
      if (done8) begin
        nd++;
        if (k1 == 0) k1 = k;
        chk("ign_p", p8, 16'h000F);
      end
    end
    chk("ign_done_count", nd, 1);
    chk("ign_done_cycle", k1, 9);

    op8(8'd2, 8'd9, 0, kd, bc);
    chk("b2b_p1", p8, 16'd18);
    op8(8'd10, 8'd10, 0, kd, bc);
    chk("b2b_gap", kd, 9);
    chk("b2b_p2", p8, 16'd100);
    repeat (2) @(negedge clk);

    start8 = 1; a8 = 7; b8 = 7; s8 = 0;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_p", p8, 0);
    @(negedge clk);
    resetn = 1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    op8(8'd6, 8'd6, 0, kd, bc);
    chk("after_rst_p", p8, 16'd36);
    repeat (2) @(negedge clk);

    chk("n4_lit_s", 8'(prod(4, 32'd8, 32'd8, 1)), 8'h40);
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(4'(x), 4'(y), s[0]);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
